ram_rd_streamer: RTL and testbench
==================================

// Module: ram_rd_streamer
// PURPOSE
//  Read sequencer that sits directly in front of sdp_ram in the GEMM operand path.
//  - On a start command, it issues a burst of `length` reads from `base_addr` (wrapping mod C_DEPTH).
//  - It collects rdata/rdata_vld into a small show-ahead FIFO.
//  - It presents the data as a valid/ready stream to the array feeder.
//  - Read issue is credit-limited, so the FIFO can never overflow under m_ready backpressure.
// PARAMETERS
//  C_DATA_WIDTH  32  width of rdata and m_data
//  C_DEPTH       4   RAM depth; address width is $clog2(C_DEPTH)
//  C_RD_LATENCY  1   ren->rdata_vld latency of the attached RAM (= its C_IN_DELAY+C_OUT_DELAY); >=0
//  C_FIFO_DEPTH  4   return-buffer entries; must be >= C_RD_LATENCY+1 (elaboration-time error otherwise)
//  C_LEN_WIDTH   $clog2(C_DEPTH)+1  width of length/remaining counters
// PORTS
//  clock      in   1             rising-edge clock
//  reset      in   1             asynchronous, active-high reset
//  start      in   1             burst request; accepted only when busy==0
//  base_addr  in   $clog2(C_DEPTH)  first read address, sampled with start
//  length     in   C_LEN_WIDTH   element count, sampled with start; 0..C_DEPTH
//  busy       out  1             burst in progress
//  done       out  1             one-cycle pulse: last element accepted on m side
//  raddr      out  $clog2(C_DEPTH)  to RAM raddr
//  ren        out  1             to RAM ren
//  rdata      in   C_DATA_WIDTH  from RAM rdata
//  rdata_vld  in   1             from RAM rdata_vld
//  m_data     out  C_DATA_WIDTH  stream data (FIFO head)
//  m_valid    out  1             stream valid
//  m_ready    in   1             stream ready; transfer when m_valid&&m_ready
// BEHAVIOUR
//  Reset values: busy=0, done=0, ren=0, raddr=0, m_valid=0, m_data=0.
//  Reset clears the FSM, all counters and the FIFO.
//  State machine:
//   - IDLE:
//     - start=1: latch base_addr/length and go to ISSUE.
//     - length==0: go to FIN instead (no reads issued).
//     - start while busy is ignored.
//   - ISSUE: ren=1 in a cycle iff issue_left>0 && (outstanding+fifo_count) < C_FIFO_DEPTH.
//     - raddr = current address.
//     - Each issue: address+1, wrapping C_DEPTH-1 -> 0; issue_left-1; outstanding+1.
//     - Go to DRAIN when the final read issues.
//   - DRAIN: wait until xfer_left reaches 0, then go to FIN.
//   - FIN: done=1 for exactly this cycle; busy=0; next state is IDLE.
//  busy: 1 in ISSUE/DRAIN, registered. It rises the cycle after start is accepted.
//  ren and raddr are registered outputs driven from the FSM; ren=0 outside ISSUE.
//  Return path:
//   - rdata_vld && outstanding>0: push rdata into the FIFO and decrement outstanding.
//   - rdata_vld with outstanding==0 (stale RAM pipeline after reset) is dropped.
//  FIFO: show-ahead. m_valid = !empty; m_data = head entry.
//   - Push and pop in the same cycle are both allowed; fifo_count is unchanged.
//   - Push into a full FIFO cannot occur by construction; the bench asserts it.
//  Each m transfer decrements xfer_left.
//   - done coincides with the cycle after the last transfer (FIN).
//  Throughput: with m_ready held at 1 and C_FIFO_DEPTH>=C_RD_LATENCY+1, one element per cycle.
//  Latency: first m_valid appears at start + 2 + C_RD_LATENCY cycles.
//  Wrap-around: base_addr=C_DEPTH-1 with length=2 reads C_DEPTH-1, then 0.
//  Reset mid-burst: everything returns to reset values next edge; new start is accepted once reset deasserts.
// TESTING
//  1. C_DEPTH=4, RAM holds {A,B,C,D}; start base=1 len=3, m_ready=1 -> m stream B,C,D on consecutive cycles; done 1 cycle after D; busy low thereafter.
//  2. base=3 len=4 -> raddr sequence 3,0,1,2; stream D,A,B,C.
//  3. len=0 -> no ren; done pulses at cycle start+1; m_valid stays 0.
//  4. len=4, m_ready=0 for 10 cycles then 1 -> exactly C_FIFO_DEPTH reads issued before stall; no FIFO overflow; all 4 words in order.
//  5. Random m_ready (50%), C_RD_LATENCY=3, C_FIFO_DEPTH=4 -> output order equals address order; outstanding+fifo_count <= 4 every cycle.
//  6. Assert reset during ISSUE with reads in flight -> outputs zero; stale rdata_vld dropped; a following start base=0 len=2 streams A,B only.

Source files
------------

// File: rtl/ram_rd_streamer.sv
// Burst read sequencer in front of sdp_ram: issues credit-limited reads, buffers the
// returning words in a show-ahead FIFO and presents them as a valid/ready stream.
module ram_rd_streamer #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DEPTH      = 4,
  parameter int C_RD_LATENCY = 1,
  parameter int C_FIFO_DEPTH = 4,
  parameter int C_LEN_WIDTH  = $clog2(C_DEPTH) + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(C_DEPTH)-1:0] base_addr,
  input  logic [C_LEN_WIDTH-1:0]     length,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(C_DEPTH)-1:0] raddr,
  output logic                       ren,
  input  logic [C_DATA_WIDTH-1:0]    rdata,
  input  logic                       rdata_vld,
  output logic [C_DATA_WIDTH-1:0]    m_data,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = $clog2(C_FIFO_DEPTH + 1);
  localparam int PW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int LW = C_LEN_WIDTH;
  localparam logic [CW:0] FIFO_DEPTH_C = (CW + 1)'(C_FIFO_DEPTH);

  if (C_FIFO_DEPTH < C_RD_LATENCY + 1) begin : g_bad_fifo_depth
    $error("ram_rd_streamer: C_FIFO_DEPTH must be >= C_RD_LATENCY+1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [AW-1:0]           r_addr;
  logic [LW-1:0]           r_issue_left;
  logic [LW-1:0]           r_xfer_left;
  logic [CW-1:0]           r_outstanding;
  logic [CW-1:0]           r_count;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [C_DATA_WIDTH-1:0] r_mem [C_FIFO_DEPTH];
  logic                    r_ren;
  logic [AW-1:0]           r_raddr;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_push;
  logic                    w_pop;
  logic [CW:0]             w_inflight;
  logic                    w_credit_ok;
  logic                    w_issue;
  logic [AW-1:0]           w_issue_addr;
  logic [AW-1:0]           w_addr_inc;
  logic [LW-1:0]           w_xfer_dec;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(C_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Returns with nothing outstanding are leftovers from before a reset and are dropped.
  assign w_push  = rdata_vld && (r_outstanding != '0);
  assign w_pop   = m_valid && m_ready;
  assign m_valid = (r_count != '0);
  assign m_data  = r_mem[r_rd_ptr];

  // A slot freed by this cycle's pop can be reused by this cycle's issue decision.
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_count} - {{CW{1'b0}}, w_pop};
  assign w_credit_ok = (w_inflight < FIFO_DEPTH_C);
  assign w_addr_inc  = (w_issue_addr == AW'(C_DEPTH - 1)) ? '0 : w_issue_addr + 1'b1;
  assign w_xfer_dec  = r_xfer_left - LW'(w_pop);

  assign ren   = r_ren;
  assign raddr = r_raddr;
  assign busy  = r_busy;
  assign done  = r_done;

  // The first read is issued straight from IDLE so data arrives one cycle sooner.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_addr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_state_nxt = S_FIN;
          end else begin
            w_issue      = 1'b1;
            w_issue_addr = base_addr;
            w_state_nxt  = (length == LW'(1)) ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if ((r_issue_left != '0) && w_credit_ok) begin
          w_issue = 1'b1;
          if (r_issue_left == LW'(1)) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_xfer_dec == '0) w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_issue_left  <= '0;
      r_xfer_left   <= '0;
      r_outstanding <= '0;
      r_ren         <= 1'b0;
      r_raddr       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy        <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
      r_done        <= (w_state_nxt == S_FIN);
      r_ren         <= w_issue;
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_push);
      if (w_issue) begin
        r_raddr <= w_issue_addr;
        r_addr  <= w_addr_inc;
      end
      if ((r_state == S_IDLE) && start) begin
        r_issue_left <= length - LW'(w_issue);
        r_xfer_left  <= length;
      end else begin
        if (w_issue) r_issue_left <= r_issue_left - LW'(1);
        r_xfer_left <= w_xfer_dec;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C_FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= rdata;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer: one instance behind a 1-cycle RAM model and one
// behind a 3-cycle RAM model, with stream/raddr/done logs checked against the RAM image.
module tb_ram_rd_streamer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int FD    = 4;
  localparam int AW    = 2;
  localparam int LW    = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  logic [DW-1:0] ram [DEPTH] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};

  // Unit 1 sits behind a latency-1 RAM, unit 3 behind a latency-3 RAM.
  logic          start1 = 1'b0, start3 = 1'b0;
  logic [AW-1:0] base1 = '0, base3 = '0;
  logic [LW-1:0] len1 = '0, len3 = '0;
  logic          mready1 = 1'b0, mready3 = 1'b0;
  logic          busy1, done1, ren1, rvld1, mvalid1;
  logic          busy3, done3, ren3, rvld3, mvalid3;
  logic [AW-1:0] raddr1, raddr3;
  logic [DW-1:0] rdata1, rdata3, mdata1, mdata3;

  ram_rd_streamer #(.C_DATA_WIDTH(DW), .C_DEPTH(DEPTH), .C_RD_LATENCY(1), .C_FIFO_DEPTH(FD)) u1 (
    .clock(clock), .reset(reset), .start(start1), .base_addr(base1), .length(len1),
    .busy(busy1), .done(done1), .raddr(raddr1), .ren(ren1), .rdata(rdata1),
    .rdata_vld(rvld1), .m_data(mdata1), .m_valid(mvalid1), .m_ready(mready1));

  ram_rd_streamer #(.C_DATA_WIDTH(DW), .C_DEPTH(DEPTH), .C_RD_LATENCY(3), .C_FIFO_DEPTH(FD)) u3 (
    .clock(clock), .reset(reset), .start(start3), .base_addr(base3), .length(len3),
    .busy(busy3), .done(done3), .raddr(raddr3), .ren(ren3), .rdata(rdata3),
    .rdata_vld(rvld3), .m_data(mdata3), .m_valid(mvalid3), .m_ready(mready3));

  // RAM models keep running through DUT reset, so reads in flight still come back afterwards.
  logic          p1Vld = 1'b0;
  logic [DW-1:0] p1Dat = '0;
  always @(posedge clock) begin
    p1Vld <= ren1;
    p1Dat <= ram[raddr1];
  end
  assign rvld1  = p1Vld;
  assign rdata1 = p1Dat;

  logic [2:0]         p3Vld = '0;
  logic [2:0][DW-1:0] p3Dat = '0;
  always @(posedge clock) begin
    p3Vld <= {p3Vld[1:0], ren3};
    p3Dat <= {p3Dat[1:0], ram[raddr3]};
  end
  assign rvld3  = p3Vld[2];
  assign rdata3 = p3Dat[2];

  // Mid-cycle logs of what each unit did; issued-minus-popped equals outstanding+fifo_count.
  logic [DW-1:0] q1Data[$], q3Data[$];
  logic [AW-1:0] q1Addr[$], q3Addr[$];
  int            q1Cyc[$], q3Cyc[$], q1Done[$], q3Done[$];
  int            busy1Cnt = 0, valid1Cnt = 0, iss1 = 0, pop1 = 0, max1 = 0;
  int            busy3Cnt = 0, valid3Cnt = 0, iss3 = 0, pop3 = 0, max3 = 0, vld3Cnt = 0;

  always @(negedge clock) begin
    if (reset) begin
      iss1 <= 0;
      pop1 <= 0;
    end else begin
      if (ren1) q1Addr.push_back(raddr1);
      iss1 <= iss1 + int'(ren1);
      max1 <= ((iss1 + int'(ren1) - pop1) > max1) ? (iss1 + int'(ren1) - pop1) : max1;
      if (mvalid1) valid1Cnt <= valid1Cnt + 1;
      if (mvalid1 && mready1) begin
        q1Data.push_back(mdata1);
        q1Cyc.push_back(cyc);
        pop1 <= pop1 + 1;
      end
      if (done1) q1Done.push_back(cyc);
      if (busy1) busy1Cnt <= busy1Cnt + 1;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      iss3 <= 0;
      pop3 <= 0;
    end else begin
      if (ren3) q3Addr.push_back(raddr3);
      iss3 <= iss3 + int'(ren3);
      max3 <= ((iss3 + int'(ren3) - pop3) > max3) ? (iss3 + int'(ren3) - pop3) : max3;
      if (rvld3) vld3Cnt <= vld3Cnt + 1;
      if (mvalid3) valid3Cnt <= valid3Cnt + 1;
      if (mvalid3 && mready3) begin
        q3Data.push_back(mdata3);
        q3Cyc.push_back(cyc);
        pop3 <= pop3 + 1;
      end
      if (done3) q3Done.push_back(cyc);
      if (busy3) busy3Cnt <= busy3Cnt + 1;
    end
  end

  // One immediate-assertion comparison; every failure is counted and reported.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearLogs();
    q1Data.delete(); q1Addr.delete(); q1Cyc.delete(); q1Done.delete();
    q3Data.delete(); q3Addr.delete(); q3Cyc.delete(); q3Done.delete();
    busy1Cnt = 0; valid1Cnt = 0; max1 = 0;
    busy3Cnt = 0; valid3Cnt = 0; max3 = 0; vld3Cnt = 0;
  endtask

  // Pulse start for one cycle on the chosen unit; t records the cycle start was high.
  task automatic applyStimulus(input int unit, input int base, input int len);
    if (unit == 1) begin
      start1 = 1'b1; base1 = AW'(base); len1 = LW'(len);
    end else begin
      start3 = 1'b1; base3 = AW'(base); len3 = LW'(len);
    end
    t = cyc;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  // Stream data and raddr order must follow the RAM image from base, wrapping at DEPTH.
  task automatic checkStream(input string tag, input int unit, input int base, input int n);
    checkOutput({tag, " stream count"}, 64'((unit == 1) ? q1Data.size() : q3Data.size()), 64'(n));
    checkOutput({tag, " read count"}, 64'((unit == 1) ? q1Addr.size() : q3Addr.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " data"}, 64'((unit == 1) ? q1Data[i] : q3Data[i]), 64'(ram[(base + i) % DEPTH]));
      checkOutput({tag, " raddr"}, 64'((unit == 1) ? q1Addr[i] : q3Addr[i]), 64'((base + i) % DEPTH));
    end
    checkOutput({tag, " done count"}, 64'((unit == 1) ? q1Done.size() : q3Done.size()), 64'd1);
  endtask

  initial begin
    // Reset state while reset is held.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset busy", 64'(busy1), 64'd0);
    checkOutput("reset done", 64'(done1), 64'd0);
    checkOutput("reset ren", 64'(ren1), 64'd0);
    checkOutput("reset raddr", 64'(raddr1), 64'd0);
    checkOutput("reset m_valid", 64'(mvalid1), 64'd0);
    checkOutput("reset m_data", 64'(mdata1), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Burst base=1 len=3 at full rate: B,C,D back to back, first at t+3, done at t+6.
    clearLogs();
    mready1 = 1'b1;
    applyStimulus(1, 1, 3);
    repeat (10) tick();
    checkStream("t1", 1, 1, 3);
    for (int i = 0; i < 3; i++) checkOutput("t1 xfer cycle", 64'(q1Cyc[i]), 64'(t + 3 + i));
    checkOutput("t1 done cycle", 64'(q1Done[0]), 64'(t + 6));
    checkOutput("t1 busy cycles", 64'(busy1Cnt), 64'd5);
    checkOutput("t1 busy after", 64'(busy1), 64'd0);

    // Wrapping burst base=3 len=4: raddr 3,0,1,2 and stream D,A,B,C.
    clearLogs();
    applyStimulus(1, 3, 4);
    repeat (10) tick();
    checkStream("t2", 1, 3, 4);
    for (int i = 0; i < 4; i++) checkOutput("t2 xfer cycle", 64'(q1Cyc[i]), 64'(t + 3 + i));
    checkOutput("t2 done cycle", 64'(q1Done[0]), 64'(t + 7));

    // Zero-length burst: no reads, no data, done one cycle after start.
    clearLogs();
    applyStimulus(1, 2, 0);
    repeat (6) tick();
    checkOutput("t3 reads", 64'(q1Addr.size()), 64'd0);
    checkOutput("t3 m_valid cycles", 64'(valid1Cnt), 64'd0);
    checkOutput("t3 busy cycles", 64'(busy1Cnt), 64'd0);
    checkOutput("t3 done count", 64'(q1Done.size()), 64'd1);
    checkOutput("t3 done cycle", 64'(q1Done[0]), 64'(t + 1));

    // Backpressure: ready low for 10 cycles; reads stop at FIFO capacity, then drain in order.
    clearLogs();
    mready1 = 1'b0;
    applyStimulus(1, 0, 4);
    repeat (9) tick();
    checkOutput("t4 reads during stall", 64'(q1Addr.size()), 64'(FD));
    checkOutput("t4 xfers during stall", 64'(q1Data.size()), 64'd0);
    checkOutput("t4 m_valid held", 64'(mvalid1), 64'd1);
    mready1 = 1'b1;
    repeat (8) tick();
    checkStream("t4", 1, 0, 4);
    checkOutput("t4 done cycle", 64'(q1Done[0]), 64'(t + 14));
    checkOutput("t4 peak occupancy", 64'(max1), 64'(FD));

    // Latency-3 unit with random ready: order follows addresses, occupancy never exceeds FD.
    clearLogs();
    mready3 = 1'($urandom_range(0, 1));
    applyStimulus(3, 2, 4);
    repeat (40) begin
      mready3 = 1'($urandom_range(0, 1));
      tick();
    end
    mready3 = 1'b1;
    repeat (20) tick();
    checkStream("t5a", 3, 2, 4);
    checkOutput("t5a occupancy bound", 64'(max3 <= FD), 64'd1);
    clearLogs();
    applyStimulus(3, 1, 3);
    repeat (40) begin
      mready3 = 1'($urandom_range(0, 1));
      tick();
    end
    mready3 = 1'b1;
    repeat (20) tick();
    checkStream("t5b", 3, 1, 3);
    checkOutput("t5b occupancy bound", 64'(max3 <= FD), 64'd1);
    checkOutput("t5b busy after", 64'(busy3), 64'd0);

    // Reset during ISSUE with reads at t+1 and t+2 still in the RAM pipeline.
    clearLogs();
    mready3 = 1'b0;
    applyStimulus(3, 0, 4);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t6 reset busy", 64'(busy3), 64'd0);
    checkOutput("t6 reset ren", 64'(ren3), 64'd0);
    checkOutput("t6 reset raddr", 64'(raddr3), 64'd0);
    checkOutput("t6 reset m_valid", 64'(mvalid3), 64'd0);
    checkOutput("t6 reset m_data", 64'(mdata3), 64'd0);
    tick();
    reset = 1'b0;
    clearLogs();
    mready3 = 1'b1;
    repeat (6) tick();
    checkOutput("t6 stale returns seen", 64'(vld3Cnt), 64'd2);
    checkOutput("t6 stale data dropped", 64'(valid3Cnt), 64'd0);
    clearLogs();
    applyStimulus(3, 0, 2);
    repeat (15) tick();
    checkStream("t6", 3, 0, 2);
    checkOutput("t6 idle after", 64'(mvalid3), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
